// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the parametrised memory controller.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package mem_ctrl_pkg;

  // Controller states; encoding is fixed so state values are stable across builds
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Request opcode values carried on req_op
  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/mem_array.sv
// DATA_W x DEPTH register file with one shared address for read and write.
// Latency: write commits at the clock edge; read data is combinational from addr.
// Backpressure: none; the controller decides when to write and when to sample.
module mem_array #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage update: reset clears every word and overrides any pending write
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst) begin
        mem[i] <= '0;
      end else if (we && (addr == ADDR_W'(i))) begin
        mem[i] <= wdata;
      end
    end
  end

  // Read mux; addresses past the last word read as zero rather than indexing out of range
  always_comb begin
    rdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == ADDR_W'(i)) begin
        rdata = mem[i];
      end
    end
  end

endmodule

// File: rtl/mem_ctrl_param.sv
// Single-port memory behind a valid/ready request channel with one response per request.
// Latency: accept edge N -> WRITE/READ for one cycle -> response held valid from the next edge.
// Backpressure: response held stable until rsp_ready; no new request accepted until back in IDLE.
module mem_ctrl_param
  import mem_ctrl_pkg::*;
#(
  parameter int   DATA_W = 8,
  parameter int   DEPTH  = 8,
  localparam int  ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  // DEPTH widened by one bit so that DEPTH == 2**ADDR_W still compares correctly
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              in_range;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  // Range check on the captured address only, so req_* changes after accept are ignored
  assign in_range = ({1'b0, addr_q} < DEPTH_V);
  assign mem_we   = (state_q == ST_WRITE) && in_range;

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  // State register; reset drops any request in flight without a response
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs, all decoded from state alone
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          state_d = (req_op == OP_WRITE) ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: state_d = ST_RESP;
      ST_READ:  state_d = ST_RESP;
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request capture on acceptance in IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else if ((state_q == ST_IDLE) && req_valid) begin
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Response registers loaded in WRITE/READ and held through RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_WRITE: begin
          rdata_q <= '0;
          err_q   <= !in_range;
        end
        ST_READ: begin
          rdata_q <= in_range ? mem_rdata : '0;
          err_q   <= !in_range;
        end
        default: begin
          rdata_q <= rdata_q;
          err_q   <= err_q;
        end
      endcase
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_mem_ctrl_param.sv
// Bench for mem_ctrl_param: an 8x8 instance and a 16x6 instance share stimulus, selected by sel.
// Latency: checks two cycles from acceptance to rsp_valid.
// Backpressure: holds rsp_ready low for several cycles and checks the response stays put.
module tb_mem_ctrl_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        req_valid;
  logic        req_op;
  logic [2:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_ready;

  logic        r8_req_ready, r8_rsp_valid, r8_err, r8_busy;
  logic [7:0]  r8_rdata;
  logic        r6_req_ready, r6_rsp_valid, r6_err, r6_busy;
  logic [15:0] r6_rdata;

  logic        s_req_ready, s_rsp_valid, s_err, s_busy;
  logic [15:0] s_rdata;

  int checks = 0;
  int errors = 0;

  logic [15:0] m8 [8];
  logic [15:0] m6 [6];

  typedef struct {
    logic        s;
    logic        op;
    logic [2:0]  a;
    logic [15:0] wd;
    logic [15:0] rd;
    logic        er;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  mem_ctrl_param #(.DATA_W(8), .DEPTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid & ~sel),
    .req_ready (r8_req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata[7:0]),
    .rsp_valid (r8_rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (r8_rdata),
    .rsp_err   (r8_err),
    .busy      (r8_busy)
  );

  mem_ctrl_param #(.DATA_W(16), .DEPTH(6)) dut6 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid & sel),
    .req_ready (r6_req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (r6_rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (r6_rdata),
    .rsp_err   (r6_err),
    .busy      (r6_busy)
  );

  always_comb begin
    s_req_ready = sel ? r6_req_ready : r8_req_ready;
    s_rsp_valid = sel ? r6_rsp_valid : r8_rsp_valid;
    s_err       = sel ? r6_err       : r8_err;
    s_busy      = sel ? r6_busy      : r8_busy;
    s_rdata     = sel ? r6_rdata     : {8'h00, r8_rdata};
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m8[i] = '0;
    for (int i = 0; i < 6; i++) m6[i] = '0;
  endtask

  // Reference: memory as plain arrays; writes answer 0, out-of-range answers 0 with error
  task automatic model_apply(input logic s, input logic op, input logic [2:0] a,
                             input logic [15:0] wd, output logic [15:0] rd, output logic er);
    int depth;
    depth = s ? 6 : 8;
    rd = '0;
    er = 1'b0;
    if (int'(a) >= depth) begin
      er = 1'b1;
    end else if (op) begin
      if (s) m6[int'(a)] = wd;
      else   m8[int'(a)] = {8'h00, wd[7:0]};
    end else begin
      rd = s ? m6[int'(a)] : m8[int'(a)];
    end
  endtask

  // One request/response; entered and left at a falling edge with the DUT in IDLE
  task automatic txn(input logic s, input logic op, input logic [2:0] a, input logic [15:0] wd,
                     input int hold, input logic [15:0] exp_rd, input logic exp_er);
    int lat;
    sel       = s;
    req_op    = op;
    req_addr  = a;
    req_wdata = wd;
    req_valid = 1'b1;
    rsp_ready = 1'b0;
    chk("req_ready_idle", s_req_ready, 1);
    @(posedge clk); #1;
    // Scramble the request lines after acceptance; the DUT must ignore them
    req_valid = 1'b0;
    req_op    = 1'($urandom);
    req_addr  = 3'($urandom);
    req_wdata = 16'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!s_rsp_valid && lat < 10);
    chk("rsp_latency", lat, 2);
    chk("busy_in_resp", s_busy, 1);
    // A competing request during backpressure must not be accepted
    req_valid = (hold > 0);
    for (int i = 0; i < hold; i++) begin
      chk("rsp_valid_held", s_rsp_valid, 1);
      chk("rsp_rdata_held", s_rdata, exp_rd);
      chk("req_ready_held", s_req_ready, 0);
      @(negedge clk);
    end
    chk("rsp_rdata", s_rdata, exp_rd);
    chk("rsp_err", s_err, exp_er);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rsp_valid_done", s_rsp_valid, 0);
    chk("req_ready_after", s_req_ready, 1);
  endtask

  task automatic add_vec(input logic s, input logic op, input logic [2:0] a, input logic [15:0] wd,
                         input logic [15:0] rd, input logic er);
    vec_t v;
    v.s = s; v.op = op; v.a = a; v.wd = wd; v.rd = rd; v.er = er;
    vecs.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] erd;
    logic        eer;
    logic        s, op;
    logic [2:0]  a;
    logic [15:0] wd;

    sel = 1'b0; req_valid = 1'b0; req_op = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    model_clear();

    chk("rst_req_ready8", r8_req_ready, 1);
    chk("rst_rsp_valid8", r8_rsp_valid, 0);
    chk("rst_rdata8",     r8_rdata, 0);
    chk("rst_err8",       r8_err, 0);
    chk("rst_busy8",      r8_busy, 0);
    chk("rst_req_ready6", r6_req_ready, 1);
    chk("rst_rsp_valid6", r6_rsp_valid, 0);
    chk("rst_busy6",      r6_busy, 0);

    // Directed table: fresh reads, first writes, read-back, range errors on the 6-deep instance
    for (int i = 0; i < 8; i++) add_vec(0, 0, 3'(i), 0, 16'h0000, 0);
    add_vec(0, 1, 3'd0, 16'h00AA, 16'h0000, 0);
    add_vec(0, 1, 3'd1, 16'h0055, 16'h0000, 0);
    add_vec(0, 0, 3'd0, 16'h0000, 16'h00AA, 0);
    add_vec(0, 0, 3'd1, 16'h0000, 16'h0055, 0);
    for (int i = 0; i < 6; i++) add_vec(1, 0, 3'(i), 0, 16'h0000, 0);
    add_vec(1, 1, 3'd7, 16'hBEEF, 16'h0000, 1);
    add_vec(1, 0, 3'd7, 16'h0000, 16'h0000, 1);
    add_vec(1, 1, 3'd6, 16'h1234, 16'h0000, 1);
    add_vec(1, 0, 3'd6, 16'h0000, 16'h0000, 1);
    add_vec(1, 1, 3'd5, 16'hCAFE, 16'h0000, 0);
    add_vec(1, 0, 3'd5, 16'h0000, 16'hCAFE, 0);
    for (int i = 0; i < 5; i++) add_vec(1, 0, 3'(i), 0, 16'h0000, 0);

    foreach (vecs[i]) begin
      model_apply(vecs[i].s, vecs[i].op, vecs[i].a, vecs[i].wd, erd, eer);
      txn(vecs[i].s, vecs[i].op, vecs[i].a, vecs[i].wd, 0, vecs[i].rd, vecs[i].er);
    end

    // Backpressure: read addr 1 and hold rsp_ready low for 5 cycles
    txn(0, 0, 3'd1, 16'h0000, 5, 16'h0055, 0);

    // Request lines change right after acceptance of write 0x11 to addr 3
    model_apply(0, 1, 3'd3, 16'h0011, erd, eer);
    txn(0, 1, 3'd3, 16'h0011, 0, 16'h0000, 0);
    for (int i = 0; i < 8; i++) begin
      model_apply(0, 0, 3'(i), 0, erd, eer);
      txn(0, 0, 3'(i), 0, 0, erd, eer);
    end

    // Randomised traffic against the array model
    for (int n = 0; n < 120; n++) begin
      s  = 1'($urandom_range(0, 1));
      op = 1'($urandom_range(0, 1));
      a  = 3'($urandom_range(0, 7));
      wd = 16'($urandom);
      model_apply(s, op, a, wd, erd, eer);
      txn(s, op, a, wd, $urandom_range(0, 2), erd, eer);
    end

    // Reset during the WRITE cycle: no response, no commit, storage cleared
    sel = 1'b0; req_op = 1'b1; req_addr = 3'd2; req_wdata = 16'h003C; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("busy_in_write", r8_busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_rsp_after_rst", r8_rsp_valid, 0);
    end
    chk("ready_after_rst", r8_req_ready, 1);
    chk("busy_after_rst", r8_busy, 0);
    txn(0, 0, 3'd2, 16'h0000, 0, 16'h0000, 0);
    txn(1, 0, 3'd5, 16'h0000, 0, 16'h0000, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
